// File: rtl/proj_sorter_ctrl.sv
// Sequencer in front of proj_sorter: clears it, streams indexed signatures through one
// stage register, and captures the smallest-K index list once the last element has settled.
module proj_sorter_ctrl #(
    parameter int INDICES_COUNT = 4,
    parameter int INDICE_LEN    = 8,
    parameter int SIGNATURE_LEN = 16,
    parameter int CNT_W         = INDICE_LEN + 1
) (
    input  logic                            in_clk,
    input  logic                            in_rst_n,
    input  logic                            in_start,
    input  logic [CNT_W-1:0]                in_count,
    input  logic                            in_abort,
    output logic                            out_busy,
    input  logic                            in_sig_valid,
    input  logic [SIGNATURE_LEN-1:0]        in_signature,
    output logic                            out_sig_ready,
    output logic                            out_sorter_rst_n,
    output logic [SIGNATURE_LEN-1:0]        out_sorter_signature,
    output logic [INDICE_LEN-1:0]           out_sorter_index,
    input  logic [INDICES_COUNT-1:0][7:0]   in_sorter_smallest_idx,
    output logic [INDICES_COUNT-1:0][7:0]   out_result,
    output logic [CNT_W-1:0]                out_result_count,
    output logic                            out_result_valid,
    output logic                            out_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FEED, S_DRAIN1, S_DRAIN2, S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] N_MAX = {1'b1, {INDICE_LEN{1'b0}}};
    localparam logic [CNT_W-1:0] K_CNT = CNT_W'(INDICES_COUNT);

    function automatic logic [CNT_W-1:0] sat_min(input logic [CNT_W-1:0] a,
                                                  input logic [CNT_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    state_t                          state_q, state_d;
    logic [CNT_W-1:0]                n_q;
    logic [CNT_W-1:0]                acc_cnt_q;
    logic [INDICE_LEN-1:0]           idx_cnt_q;
    logic [SIGNATURE_LEN-1:0]        stage_sig_q;
    logic [INDICE_LEN-1:0]           stage_idx_q;
    logic                            sorter_rst_n_q;
    logic [INDICES_COUNT-1:0][7:0]   result_q;
    logic [CNT_W-1:0]                result_count_q;
    logic                            result_valid_q;

    logic accept;
    logic last_accept;
    logic start_ok;

    assign accept      = in_sig_valid & out_sig_ready;
    assign last_accept = accept && ((acc_cnt_q + CNT_W'(1)) == n_q);
    assign start_ok    = (state_q == S_IDLE) && in_start && !in_abort;

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (in_abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   if (in_start) state_d = S_CLEAR;
                S_CLEAR:  state_d = (n_q != '0) ? S_FEED : S_DRAIN1;
                S_FEED:   if (last_accept) state_d = S_DRAIN1;
                S_DRAIN1: state_d = S_DRAIN2;
                S_DRAIN2: state_d = S_DONE;
                S_DONE:   state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Ready drops in the abort cycle so no element is taken while the job is being abandoned.
    always_comb begin
        out_busy      = (state_q != S_IDLE);
        out_sig_ready = (state_q == S_FEED) && !in_abort;
        out_done      = (state_q == S_DONE);
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            sorter_rst_n_q <= 1'b0;
            stage_sig_q    <= '1;
            stage_idx_q    <= '0;
            n_q            <= '0;
            acc_cnt_q      <= '0;
            idx_cnt_q      <= '0;
            result_q       <= '0;
            result_count_q <= '0;
            result_valid_q <= 1'b0;
        end else begin
            // Registered clear: low for exactly the CLEAR cycle, sorter wipes on the edge ending it.
            sorter_rst_n_q <= (state_d != S_CLEAR);

            // Bubble (all-ones signature) matches sorter reset contents, so idle cycles are inert.
            if (accept) begin
                stage_sig_q <= in_signature;
                stage_idx_q <= idx_cnt_q;
            end else begin
                stage_sig_q <= '1;
                stage_idx_q <= '0;
            end

            if (start_ok) begin
                n_q <= sat_min(in_count, N_MAX);
            end

            if (state_q == S_CLEAR) begin
                acc_cnt_q <= '0;
                idx_cnt_q <= '0;
            end else if (accept) begin
                acc_cnt_q <= acc_cnt_q + CNT_W'(1);
                idx_cnt_q <= idx_cnt_q + INDICE_LEN'(1);
            end

            if (in_abort || start_ok) begin
                result_valid_q <= 1'b0;
            end else if (state_q == S_DRAIN2) begin
                result_valid_q <= 1'b1;
                result_q       <= in_sorter_smallest_idx;
                result_count_q <= sat_min(n_q, K_CNT);
            end
        end
    end

    assign out_sorter_rst_n     = sorter_rst_n_q;
    assign out_sorter_signature = stage_sig_q;
    assign out_sorter_index     = stage_idx_q;
    assign out_result           = result_q;
    assign out_result_count     = result_count_q;
    assign out_result_valid     = result_valid_q;

endmodule

// File: tb/tb_proj_sorter_ctrl.sv
// Bench for proj_sorter_ctrl: behavioural sorter stand-in, a per-cycle job-level model,
// and directed jobs with literal expected index lists and latencies.
module tb_proj_sorter_ctrl;

    localparam int K  = 4;
    localparam int IL = 8;
    localparam int SW = 16;
    localparam int CW = IL + 1;

    logic               in_clk;
    logic               in_rst_n;
    logic               in_start;
    logic [CW-1:0]      in_count;
    logic               in_abort;
    logic               out_busy;
    logic               in_sig_valid;
    logic [SW-1:0]      in_signature;
    logic               out_sig_ready;
    logic               out_sorter_rst_n;
    logic [SW-1:0]      out_sorter_signature;
    logic [IL-1:0]      out_sorter_index;
    logic [K-1:0][7:0]  in_sorter_smallest_idx;
    logic [K-1:0][7:0]  out_result;
    logic [CW-1:0]      out_result_count;
    logic               out_result_valid;
    logic               out_done;

    proj_sorter_ctrl #(
        .INDICES_COUNT(K), .INDICE_LEN(IL), .SIGNATURE_LEN(SW), .CNT_W(CW)
    ) dut (
        .in_clk(in_clk), .in_rst_n(in_rst_n), .in_start(in_start), .in_count(in_count),
        .in_abort(in_abort), .out_busy(out_busy), .in_sig_valid(in_sig_valid),
        .in_signature(in_signature), .out_sig_ready(out_sig_ready),
        .out_sorter_rst_n(out_sorter_rst_n), .out_sorter_signature(out_sorter_signature),
        .out_sorter_index(out_sorter_index), .in_sorter_smallest_idx(in_sorter_smallest_idx),
        .out_result(out_result), .out_result_count(out_result_count),
        .out_result_valid(out_result_valid), .out_done(out_done)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Sorter stand-in: ascending, equal signature places the newer entry ahead of the older.
    logic [SW-1:0] srt_sig [K];
    logic [IL-1:0] srt_idx [K];
    always @(posedge in_clk) begin
        logic [SW-1:0] ts [K];
        logic [IL-1:0] ti [K];
        int p;
        if (!out_sorter_rst_n) begin
            for (int k = 0; k < K; k++) begin
                srt_sig[k] <= '1;
                srt_idx[k] <= '0;
            end
        end else begin
            for (int k = 0; k < K; k++) begin
                ts[k] = srt_sig[k];
                ti[k] = srt_idx[k];
            end
            p = K;
            for (int k = K - 1; k >= 0; k--) if (out_sorter_signature <= ts[k]) p = k;
            for (int k = K - 1; k > p; k--) begin
                ts[k] = ts[k-1];
                ti[k] = ti[k-1];
            end
            if (p < K) begin
                ts[p] = out_sorter_signature;
                ti[p] = out_sorter_index;
            end
            for (int k = 0; k < K; k++) begin
                srt_sig[k] <= ts[k];
                srt_idx[k] <= ti[k];
            end
        end
    end
    always_comb for (int k = 0; k < K; k++) in_sorter_smallest_idx[k] = srt_idx[k][7:0];

    // Job-level model: what was accepted, when the job started, when it must finish.
    logic [SW-1:0] jsig [0:256];
    int   cyc = 0;
    bit   job_live = 0;
    int   s_cyc = 0, fin_cyc = 0, mn = 0, acc = 0;
    bit   fin_known = 0;
    bit   prev_acc = 0;
    logic [SW-1:0] prev_sig = '1;
    int   prev_idx = 0;
    bit   rv = 0;
    logic [31:0] exp_res = '0;
    int   exp_cnt = 0;

    function automatic logic [31:0] model_result(input int n);
        bit used [0:256];
        logic [31:0] r;
        int best;
        r = '0;
        for (int j = 0; j <= 256; j++) used[j] = 0;
        for (int k = 0; k < K; k++) begin
            if (k < n) begin
                best = -1;
                for (int j = 0; j < n; j++)
                    if (!used[j] && (best < 0 || jsig[j] < jsig[best] ||
                                     (jsig[j] == jsig[best] && j > best))) best = j;
                used[best] = 1;
                r[k*8 +: 8] = 8'(best);
            end
        end
        return r;
    endfunction

    always @(negedge in_clk) begin
        bit exp_ready, exp_done, acc_now;
        cyc++;
        if (!in_rst_n) begin
            chk("rst_busy", 64'(out_busy), 64'd0);
            chk("rst_ready", 64'(out_sig_ready), 64'd0);
            chk("rst_done", 64'(out_done), 64'd0);
            chk("rst_rvalid", 64'(out_result_valid), 64'd0);
            chk("rst_sorter_rst_n", 64'(out_sorter_rst_n), 64'd0);
            chk("rst_result", 64'(out_result), 64'd0);
            chk("rst_count", 64'(out_result_count), 64'd0);
            chk("rst_stage_sig", 64'(out_sorter_signature), 64'hFFFF);
            job_live = 0; fin_known = 0; prev_acc = 0; rv = 0; acc = 0; mn = 0;
        end else begin
            exp_ready = job_live && (cyc >= s_cyc + 2) && (acc < mn);
            exp_done  = job_live && fin_known && (cyc == fin_cyc);
            if (exp_done) begin
                rv = 1;
                exp_res = model_result(mn);
                exp_cnt = (mn < K) ? mn : K;
            end
            chk("busy", 64'(out_busy), 64'(job_live));
            if (!in_abort) chk("ready", 64'(out_sig_ready), 64'(exp_ready));
            chk("done", 64'(out_done), 64'(exp_done));
            chk("result_valid", 64'(out_result_valid), 64'(rv));
            if (rv) begin
                chk("result", 64'(out_result), 64'(exp_res));
                chk("result_count", 64'(out_result_count), 64'(exp_cnt));
            end
            chk("sorter_rst_n", 64'(out_sorter_rst_n), 64'(!(job_live && cyc == s_cyc + 1)));
            chk("stage_sig", 64'(out_sorter_signature), prev_acc ? 64'(prev_sig) : 64'hFFFF);
            chk("stage_idx", 64'(out_sorter_index), prev_acc ? 64'(IL'(prev_idx)) : 64'd0);

            acc_now  = in_sig_valid && exp_ready && !in_abort;
            prev_acc = acc_now;
            if (acc_now) begin
                prev_sig  = in_signature;
                prev_idx  = acc;
                jsig[acc] = in_signature;
                acc++;
                if (acc == mn) begin
                    fin_cyc = cyc + 3;
                    fin_known = 1;
                end
            end
            if (in_abort) begin
                job_live = 0;
                rv = 0;
            end else if (!job_live && in_start) begin
                job_live = 1;
                s_cyc = cyc;
                mn = (int'(in_count) > 256) ? 256 : int'(in_count);
                acc = 0;
                rv = 0;
                fin_known = (mn == 0);
                fin_cyc = cyc + 4;
            end else if (exp_done) begin
                job_live = 0;
            end
        end
    end

    task automatic do_start(input int n);
        @(posedge in_clk); #1;
        in_start = 1'b1;
        in_count = CW'(n);
        @(posedge in_clk); #1;
        in_start = 1'b0;
    endtask

    // Present sigs[0..n-1]; bit g of gaps idles valid on presentation cycle g (mod 8).
    task automatic feed(input int n, input logic [SW-1:0] sigs [8], input logic [7:0] gaps);
        int i = 0, g = 0, guard = 0;
        while (i < n && guard < 100) begin
            @(posedge in_clk); #1;
            if (gaps[g % 8]) begin
                in_sig_valid = 1'b0;
            end else begin
                in_sig_valid = 1'b1;
                in_signature = sigs[i];
            end
            g++;
            @(negedge in_clk);
            if (in_sig_valid && out_sig_ready) i++;
            guard++;
        end
        chk("feed_timeout", 64'(i), 64'(n));
    endtask

    // After the final accept: optionally keep offering a tiny signature, count cycles to done.
    task automatic wait_done(input bit hold, output int lat);
        @(posedge in_clk); #1;
        in_sig_valid = hold;
        in_signature = 16'h0001;
        lat = 0;
        do begin
            @(negedge in_clk);
            lat++;
        end while (!out_done && lat < 20);
        @(posedge in_clk); #1;
        in_sig_valid = 1'b0;
    endtask

    task automatic chk_res(input string nm, input int a0, input int a1, input int a2,
                           input int a3, input int cnt);
        logic [31:0] e;
        e = {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
        chk({nm, "_result"}, 64'(out_result), 64'(e));
        chk({nm, "_count"}, 64'(out_result_count), 64'(cnt));
        chk({nm, "_rvalid"}, 64'(out_result_valid), 64'd1);
    endtask

    logic [SW-1:0] sv [8];
    int lat;

    initial begin
        in_rst_n = 1'b0; in_start = 1'b0; in_count = '0; in_abort = 1'b0;
        in_sig_valid = 1'b0; in_signature = '0;
        repeat (3) @(negedge in_clk);
        #1 in_rst_n = 1'b1;

        // Async reset in the middle of feeding
        sv = '{16'd50, 16'd10, 16'd40, 16'd20, 16'd30, 16'd0, 16'd0, 16'd0};
        do_start(5);
        feed(2, sv, 8'h00);
        @(posedge in_clk); #1;
        in_rst_n = 1'b0;
        in_sig_valid = 1'b0;
        #1;
        chk("t1_ready", 64'(out_sig_ready), 64'd0);
        chk("t1_busy", 64'(out_busy), 64'd0);
        chk("t1_rvalid", 64'(out_result_valid), 64'd0);
        chk("t1_sorter_rst_n", 64'(out_sorter_rst_n), 64'd0);
        chk("t1_stage_sig", 64'(out_sorter_signature), 64'hFFFF);
        chk("t1_stage_idx", 64'(out_sorter_index), 64'd0);
        repeat (2) @(negedge in_clk);
        #1 in_rst_n = 1'b1;

        // Back-to-back, valid kept high after the fifth accept
        do_start(5);
        feed(5, sv, 8'h00);
        wait_done(1'b1, lat);
        chk("t2_latency", 64'(lat), 64'd3);
        chk_res("t2", 1, 3, 4, 2, 4);

        // Same job with idle gaps between elements
        do_start(5);
        feed(5, sv, 8'b1011_0010);
        wait_done(1'b1, lat);
        chk("t3_latency", 64'(lat), 64'd3);
        chk_res("t3", 1, 3, 4, 2, 4);

        // Fewer elements than K
        sv = '{16'd7, 16'd3, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        do_start(2);
        feed(2, sv, 8'h00);
        wait_done(1'b0, lat);
        chk("t4_latency", 64'(lat), 64'd3);
        chk_res("t4", 1, 0, 0, 0, 2);

        // Abort after three accepts, then a fresh job
        sv = '{16'd1, 16'd2, 16'd3, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        do_start(5);
        feed(3, sv, 8'h00);
        @(posedge in_clk); #1;
        in_sig_valid = 1'b0;
        in_abort = 1'b1;
        @(posedge in_clk); #1;
        in_abort = 1'b0;
        @(negedge in_clk);
        chk("t5_busy_after_abort", 64'(out_busy), 64'd0);
        chk("t5_rvalid_after_abort", 64'(out_result_valid), 64'd0);
        sv = '{16'd9, 16'd8, 16'd7, 16'd6, 16'd0, 16'd0, 16'd0, 16'd0};
        do_start(4);
        feed(4, sv, 8'h00);
        wait_done(1'b0, lat);
        chk("t5_latency", 64'(lat), 64'd3);
        chk_res("t5", 3, 2, 1, 0, 4);

        // Empty job
        do_start(0);
        wait_done(1'b0, lat);
        chk("t6_empty_latency", 64'(lat), 64'd3);
        chk_res("t6_empty", 0, 0, 0, 0, 0);

        // Start pulse during FEED must not change N
        sv = '{16'd5, 16'd4, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        do_start(2);
        feed(1, sv, 8'h00);
        @(posedge in_clk); #1;
        in_sig_valid = 1'b0;
        in_start = 1'b1;
        in_count = CW'(7);
        @(posedge in_clk); #1;
        in_start = 1'b0;
        sv = '{16'd4, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        feed(1, sv, 8'h00);
        wait_done(1'b0, lat);
        chk("t6_latency", 64'(lat), 64'd3);
        chk_res("t6", 1, 0, 0, 0, 2);

        // Start and abort together in IDLE: start is dropped
        @(posedge in_clk); #1;
        in_start = 1'b1;
        in_abort = 1'b1;
        in_count = CW'(3);
        @(posedge in_clk); #1;
        in_start = 1'b0;
        in_abort = 1'b0;
        @(negedge in_clk);
        chk("t7_busy", 64'(out_busy), 64'd0);
        chk("t7_rvalid", 64'(out_result_valid), 64'd0);

        repeat (3) @(negedge in_clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
